// File: rtl/ysyx_ifu_fetch.sv
// Instruction fetch stage: single-outstanding AR/R fetch, small instruction
// FIFO toward the IDU, and sequential-speculation check on PC redirects.
//
// state  | meaning
// IDLE   | no request on the bus; waiting for FIFO space, a redirect, or
//        | emitting a misaligned-PC fault entry
// REQ    | arvalid high, address held until arready
// WAIT   | request accepted, waiting for the response beat
module ysyx_ifu_fetch #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] PC_INIT = 32'h8000_0000,
  parameter int                DEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              change_i,
  output logic              arvalid_o,
  output logic [DATA_W-1:0] araddr_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  output logic              rready_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [31:0]       inst_o,
  output logic [DATA_W-1:0] pc_o,
  output logic              fault_o,
  output logic              good_speculation_o,
  output logic              bad_speculation_o,
  output logic [DATA_W-1:0] pc_ifu_o
);

  localparam int                PW         = $clog2(DEPTH);
  localparam logic [PW:0]       DEPTH_C    = DEPTH[PW:0];
  localparam logic [DATA_W-1:0] FETCH_STEP = DATA_W'(4);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fpc_q, fpc_d;
  logic [DATA_W-1:0] ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0] pc_ifu_q;
  logic              stale_q, stale_d;
  logic              halt_q, halt_d;
  logic              good_q, bad_q;

  logic [DATA_W-1:0] fifo_pc   [DEPTH];
  logic [31:0]       fifo_inst [DEPTH];
  logic              fifo_flt  [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count_q, count_d, cnt_after_pop;

  logic              empty, pop, push, clear, resp_done;
  logic [DATA_W-1:0] push_pc;
  logic [31:0]       push_inst;
  logic              push_flt;
  logic [DATA_W-1:0] expect_pc;
  logic              redir_good, redir_bad, misaligned;

  assign empty         = (count_q == '0);
  assign valid_o       = !empty && !change_i;
  assign pop           = valid_o && ready_i;
  assign cnt_after_pop = count_q - {{PW{1'b0}}, pop};
  // The sequential guess is whatever would be delivered next.
  assign expect_pc     = empty ? fpc_q : fifo_pc[rd_ptr];
  assign redir_good    = change_i && (pc_i == expect_pc);
  assign redir_bad     = change_i && (pc_i != expect_pc);
  assign misaligned    = (fpc_q[1:0] != 2'b00);

  assign arvalid_o          = (state_q == S_REQ);
  assign araddr_o           = ar_addr_q;
  assign rready_o           = (state_q == S_WAIT);
  assign inst_o             = fifo_inst[rd_ptr];
  assign pc_o               = fifo_pc[rd_ptr];
  assign fault_o            = fifo_flt[rd_ptr];
  assign good_speculation_o = good_q;
  assign bad_speculation_o  = bad_q;
  assign pc_ifu_o           = pc_ifu_q;

  // Next-state, fetch PC, stale tracking and FIFO push selection.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    ar_addr_d = ar_addr_q;
    stale_d   = stale_q;
    halt_d    = halt_q;
    push      = 1'b0;
    push_pc   = fpc_q;
    push_inst = '0;
    push_flt  = 1'b0;
    clear     = redir_bad;
    resp_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (redir_bad) begin
          fpc_d  = pc_i;
          halt_d = 1'b0;
          if (pc_i[1:0] == 2'b00) begin
            state_d   = S_REQ;
            ar_addr_d = pc_i;
          end
        end else if (!halt_q && (cnt_after_pop < DEPTH_C)) begin
          if (misaligned) begin
            // Fault entry without touching the bus; park until redirected.
            push     = 1'b1;
            push_flt = 1'b1;
            halt_d   = 1'b1;
          end else begin
            state_d   = S_REQ;
            ar_addr_d = fpc_q;
          end
        end
      end
      S_REQ: begin
        // A redirect cannot retract the request; its response gets dropped.
        if (redir_bad) begin
          fpc_d   = pc_i;
          stale_d = 1'b1;
        end
        if (arready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid_i) begin
          resp_done = 1'b1;
          stale_d   = 1'b0;
          if (redir_bad) begin
            fpc_d = pc_i;
          end else if (!stale_q) begin
            push      = 1'b1;
            push_inst = rdata_i;
            push_flt  = (rresp_i != 2'b00);
            fpc_d     = fpc_q + FETCH_STEP;
          end
        end else if (redir_bad) begin
          fpc_d   = pc_i;
          stale_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    count_d = clear ? '0 : (cnt_after_pop + {{PW{1'b0}}, push});

    if (resp_done) begin
      if ((fpc_d[1:0] == 2'b00) && (count_d < DEPTH_C)) begin
        state_d   = S_REQ;
        ar_addr_d = fpc_d;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Control registers and speculation report pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      fpc_q     <= PC_INIT;
      ar_addr_q <= PC_INIT;
      stale_q   <= 1'b0;
      halt_q    <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
      pc_ifu_q  <= PC_INIT;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      ar_addr_q <= ar_addr_d;
      stale_q   <= stale_d;
      halt_q    <= halt_d;
      good_q    <= redir_good;
      bad_q     <= redir_bad;
      if (redir_good) pc_ifu_q <= pc_i;
    end
  end

  // Instruction FIFO storage and pointers; a bad redirect empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
        fifo_flt[i]  <= 1'b0;
      end
    end else if (clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push) begin
        fifo_pc[wr_ptr]   <= push_pc;
        fifo_inst[wr_ptr] <= push_inst;
        fifo_flt[wr_ptr]  <= push_flt;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Bench for ysyx_ifu_fetch: directed vector table, hand-written redirect and
// fault sequences, then randomized traffic against a delivery-order model.
module tb_ysyx_ifu_fetch;

  localparam logic [31:0] PC0 = 32'h8000_0000;

  logic        clk, rst;
  logic [31:0] pc_i;
  logic        change_i;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic        arready_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rready_o;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic        good_speculation_o;
  logic        bad_speculation_o;
  logic [31:0] pc_ifu_o;

  ysyx_ifu_fetch #(.DATA_W(32), .PC_INIT(PC0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .change_i(change_i),
    .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rready_o(rready_o),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o),
    .fault_o(fault_o), .good_speculation_o(good_speculation_o),
    .bad_speculation_o(bad_speculation_o), .pc_ifu_o(pc_ifu_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // Memory image seen by the fetch bus.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ PC0) << 8) | 32'h0000_0013;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return (a[4:0] == 5'h10);
  endfunction

  // ---------------- bus slave ----------------
  logic        slv_rand = 1'b0;
  logic        slv_hold = 1'b0;
  logic        hs_ar, hs_r;
  logic [31:0] hs_addr;

  always @(negedge clk) begin
    hs_ar   = arvalid_o && arready_i;
    hs_r    = rvalid_i && rready_o;
    hs_addr = araddr_o;
  end

  initial begin
    logic        pend;
    logic [31:0] paddr;
    int          dly;
    pend = 1'b0; paddr = '0; dly = 0;
    arready_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rresp_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        pend = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0;
      end else begin
        if (hs_r) begin rvalid_i = 1'b0; pend = 1'b0; end
        if (hs_ar) begin
          pend = 1'b1; paddr = hs_addr;
          dly = slv_rand ? int'($urandom_range(0, 3)) : 0;
        end
        if (pend && !rvalid_i && !slv_hold) begin
          if (dly == 0) begin
            rvalid_i = 1'b1;
            rdata_i  = mem_word(paddr);
            rresp_i  = mem_fault(paddr) ? 2'b10 : 2'b00;
          end else dly--;
        end
        arready_i = slv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        ready;
    logic        change;
    logic [31:0] pc;
    logic        hold;
    logic        arv;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pco;
    logic [31:0] inst;
    logic        flt;
    logic        good;
    logic        bad;
    logic [31:0] ifu;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [31:0] next_pc, m_ifu, prev_addr;
    logic        eg, eb, prev_stall, found, bad_addr;
    int          busy, ndel;

    //          rdy chg pc          hold arv addr          vld pco           inst          flt gd bd ifu
    tbl[0]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0};
    tbl[1]  = '{1'b0,1'b0,32'h0,      1'b0,1'b1,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0};
    tbl[2]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0};
    tbl[3]  = '{1'b0,1'b0,32'h0,      1'b0,1'b1,PC0+32'h4,   1'b1,PC0,         32'h13,      1'b0,1'b0,1'b0,PC0};
    tbl[4]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b1,PC0,         32'h13,      1'b0,1'b0,1'b0,PC0};
    tbl[5]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b1,PC0,         32'h13,      1'b0,1'b0,1'b0,PC0};
    tbl[6]  = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b1,PC0,         32'h13,      1'b0,1'b0,1'b0,PC0};
    tbl[7]  = '{1'b1,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b1,PC0,         32'h13,      1'b0,1'b0,1'b0,PC0};
    tbl[8]  = '{1'b0,1'b1,PC0+32'h4,  1'b1,1'b1,PC0+32'h8,   1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0};
    tbl[9]  = '{1'b0,1'b0,32'h0,      1'b1,1'b0,PC0,         1'b1,PC0+32'h4,   32'h413,     1'b0,1'b1,1'b0,PC0+32'h4};
    tbl[10] = '{1'b0,1'b1,PC0+32'h100,1'b1,1'b0,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0+32'h4};
    tbl[11] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b1,PC0+32'h4};
    tbl[12] = '{1'b0,1'b0,32'h0,      1'b0,1'b1,PC0+32'h100, 1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0+32'h4};
    tbl[13] = '{1'b0,1'b0,32'h0,      1'b0,1'b0,PC0,         1'b0,32'h0,       32'h0,       1'b0,1'b0,1'b0,PC0+32'h4};
    tbl[14] = '{1'b1,1'b0,32'h0,      1'b0,1'b1,PC0+32'h104, 1'b1,PC0+32'h100, 32'h10013,   1'b0,1'b0,1'b0,PC0+32'h4};

    rst = 1'b0; pc_i = '0; change_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1 ("rst_arvalid", arvalid_o, 1'b0);
    chk32("rst_araddr",  araddr_o,  PC0);
    chk1 ("rst_rready",  rready_o,  1'b0);
    chk1 ("rst_valid",   valid_o,   1'b0);
    chk32("rst_inst",    inst_o,    32'h0);
    chk32("rst_pc_o",    pc_o,      32'h0);
    chk1 ("rst_fault",   fault_o,   1'b0);
    chk1 ("rst_good",    good_speculation_o, 1'b0);
    chk1 ("rst_bad",     bad_speculation_o,  1'b0);
    chk32("rst_pc_ifu",  pc_ifu_o,  PC0);

    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      ready_i  = tbl[i].ready;
      change_i = tbl[i].change;
      pc_i     = tbl[i].pc;
      slv_hold = tbl[i].hold;
      @(negedge clk);
      chk1 ($sformatf("row%0d_arvalid", i), arvalid_o, tbl[i].arv);
      if (tbl[i].arv) chk32($sformatf("row%0d_araddr", i), araddr_o, tbl[i].addr);
      chk1 ($sformatf("row%0d_valid", i), valid_o, tbl[i].vld);
      if (tbl[i].vld) begin
        chk32($sformatf("row%0d_pc_o", i),  pc_o,    tbl[i].pco);
        chk32($sformatf("row%0d_inst", i),  inst_o,  tbl[i].inst);
        chk1 ($sformatf("row%0d_fault", i), fault_o, tbl[i].flt);
      end
      chk1 ($sformatf("row%0d_good", i),   good_speculation_o, tbl[i].good);
      chk1 ($sformatf("row%0d_bad", i),    bad_speculation_o,  tbl[i].bad);
      chk32($sformatf("row%0d_pc_ifu", i), pc_ifu_o, tbl[i].ifu);
      @(posedge clk); #1;
    end

    // Bus error on fetch at 0x80000010.
    slv_hold = 1'b0; ready_i = 1'b1; change_i = 1'b1; pc_i = PC0 + 32'h10;
    @(posedge clk); #1;
    change_i = 1'b0;
    @(negedge clk);
    chk1("fault_redir_bad", bad_speculation_o, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (valid_o) found = 1'b1;
      else @(negedge clk);
    end
    chk1 ("fault_seen",  found,   1'b1);
    chk32("fault_pc_o",  pc_o,    PC0 + 32'h10);
    chk1 ("fault_flag",  fault_o, 1'b1);
    chk32("fault_inst",  inst_o,  mem_word(PC0 + 32'h10));

    // Misaligned redirect: fault entry without a bus request, then parked.
    @(posedge clk); #1;
    change_i = 1'b1; pc_i = PC0 + 32'h102;
    @(posedge clk); #1;
    change_i = 1'b0;
    @(negedge clk);
    chk1("mis_redir_bad", bad_speculation_o, 1'b1);
    found = 1'b0; bad_addr = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (arvalid_o && araddr_o[1:0] != 2'b00) bad_addr = 1'b1;
      if (valid_o) found = 1'b1;
      else @(negedge clk);
    end
    chk1 ("mis_no_bus_req", bad_addr, 1'b0);
    chk1 ("mis_seen",  found,   1'b1);
    chk32("mis_pc_o",  pc_o,    PC0 + 32'h102);
    chk1 ("mis_fault", fault_o, 1'b1);
    chk32("mis_inst",  inst_o,  32'h0);
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (arvalid_o || valid_o) busy++;
    end
    chk32("mis_parked", 32'(busy), 32'h0);

    // Randomized traffic; the model tracks the next PC the IDU must receive.
    slv_rand = 1'b1;
    next_pc = PC0 + 32'h102;
    m_ifu = PC0 + 32'h4;
    eg = 1'b0; eb = 1'b0; prev_stall = 1'b0; prev_addr = '0; ndel = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      ready_i = ($urandom_range(0, 1) == 1);
      if (cyc == 0) begin
        change_i = 1'b1; pc_i = PC0 + 32'h1000;
      end else if ($urandom_range(0, 15) == 0) begin
        change_i = 1'b1;
        pc_i = ($urandom_range(0, 2) == 0) ? next_pc : PC0 + ($urandom_range(0, 1023) << 2);
      end else begin
        change_i = 1'b0; pc_i = $urandom;
      end
      @(negedge clk);
      chk1 ("rnd_good",   good_speculation_o, eg);
      chk1 ("rnd_bad",    bad_speculation_o,  eb);
      chk32("rnd_pc_ifu", pc_ifu_o, m_ifu);
      if (prev_stall) begin
        chk1 ("rnd_ar_hold_valid", arvalid_o, 1'b1);
        chk32("rnd_ar_hold_addr",  araddr_o,  prev_addr);
      end
      prev_stall = arvalid_o && !arready_i;
      prev_addr  = araddr_o;
      eg = 1'b0; eb = 1'b0;
      if (change_i) begin
        chk1("rnd_valid_in_change", valid_o, 1'b0);
        if (pc_i == next_pc) begin eg = 1'b1; m_ifu = pc_i; end
        else begin eb = 1'b1; next_pc = pc_i; end
      end else if (valid_o && ready_i) begin
        chk32("rnd_pc_o",  pc_o,    next_pc);
        chk32("rnd_inst",  inst_o,  mem_word(next_pc));
        chk1 ("rnd_fault", fault_o, mem_fault(next_pc));
        next_pc = next_pc + 32'h4;
        ndel++;
      end
    end
    chk1("rnd_progress", (ndel > 100), 1'b1);

    // Reset in the middle of traffic.
    @(posedge clk); #1;
    rst = 1'b0; change_i = 1'b0;
    @(negedge clk);
    chk1 ("rst2_arvalid", arvalid_o, 1'b0);
    chk1 ("rst2_valid",   valid_o,   1'b0);
    chk32("rst2_araddr",  araddr_o,  PC0);
    chk32("rst2_pc_ifu",  pc_ifu_o,  PC0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_ifu_fetch.md
Name: ysyx_ifu_fetch

Overview:
Instruction fetch stage directly downstream of the PC register. It takes the architectural PC and redirect pulse from the PC stage and fetches 32-bit instructions over a single-outstanding AR/R bus. Fetched instructions are buffered in a small FIFO and delivered to the IDU with a valid/ready handshake. On each redirect it reports back to the PC stage whether its sequential (pc+4) speculation was correct.

Parameters:
DATA_W, 32, PC and address width
PC_INIT, 32'h8000_0000, fetch PC after reset
DEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (0 = reset)
pc_i  in  DATA_W  redirect target from PC stage (npc)
change_i  in  1  redirect pulse from PC stage
arvalid_o  out  1  fetch request valid
araddr_o  out  DATA_W  fetch address
arready_i  in  1  request accepted
rvalid_i  in  1  response valid
rdata_i  in  32  instruction word
rresp_i  in  2  response status; nonzero = access fault
rready_o  out  1  response accept
valid_o  out  1  instruction valid to IDU
ready_i  in  1  IDU ready
inst_o  out  32  instruction
pc_o  out  DATA_W  instruction PC
fault_o  out  1  access fault or misaligned PC for this entry
good_speculation_o  out  1  redirect matched prediction (1-cycle pulse)
bad_speculation_o  out  1  redirect mismatched, buffer flushed (1-cycle pulse)
pc_ifu_o  out  DATA_W  PC confirmed by last good speculation

Behaviour:
- Reset (rst=0, async): state IDLE, fpc=PC_INIT, FIFO empty, stale=0; all outputs 0 except pc_ifu_o=PC_INIT, araddr_o=PC_INIT.
- States: IDLE, REQ, WAIT. IDLE -> REQ the first cycle after reset release.
- REQ: arvalid_o=1, araddr_o=fpc. Entry into REQ requires FIFO count + in-flight < DEPTH; otherwise stay in IDLE until space exists. araddr_o held stable until arready_i. On handshake -> WAIT.
- WAIT: rready_o=1. On rvalid_i: if stale=0, push {fpc, rdata_i, rresp_i!=0} and set fpc=fpc+4 (wraps mod 2^DATA_W); if stale=1, discard and clear stale. Then -> REQ if space, else IDLE.
- Misaligned fpc (fpc[1:0]!=0): no bus request. Push {fpc, 32'h0, fault=1} directly from IDLE/REQ, then hold in IDLE until redirect.
- Delivery: valid_o = FIFO nonempty & !change_i. Head pops on valid_o & ready_i. Push and pop in the same cycle are allowed when full (pop first).
- Prediction check on change_i: expected = FIFO head PC if nonempty, else fpc.
  - Equal: next cycle good_speculation_o=1, pc_ifu_o=pc_i. No other state change.
  - Different: next cycle bad_speculation_o=1. FIFO cleared this cycle, fpc<=pc_i.
    - If a request is in REQ (arvalid high) or WAIT: stale<=1, keep address/handshake until complete, then discard.
    - If in IDLE: -> REQ at pc_i.
- A redirect arriving while stale=1 overwrites fpc only. At most one stale response is outstanding.
- good and bad speculation pulses are mutually exclusive and last exactly one cycle.
- Reset asserted mid-transaction abandons the outstanding response. The bus is assumed reset together with this block.

Test Plan:
- Reset release, arready_i=1, 1-cycle rvalid_i with rdata 0x00000013 -> araddr_o 0x80000000 then 0x80000004. IDU gets pc_o 0x80000000, inst_o 0x00000013, fault_o=0.
- ready_i=0 with DEPTH=2 -> exactly two entries buffered (0x80000000, 0x80000004). No third arvalid_o until one pop.
- change_i with pc_i=0x80000004 while head pc=0x80000004 -> good_speculation_o=1 next cycle, pc_ifu_o=0x80000004, FIFO intact.
- change_i with pc_i=0x80000100 while WAIT for 0x80000008 -> bad_speculation_o=1 next cycle. FIFO empty, response for 0x80000008 dropped, next araddr_o 0x80000100.
- rresp_i=2'b10 on fetch at 0x80000010 -> entry delivered with fault_o=1, pc_o 0x80000010.
- change_i with pc_i=0x80000102 -> bad_speculation_o=1, no bus request. Entry pc_o 0x80000102, fault_o=1, inst_o 0.
